// File: rtl/counter_checker.sv
// Hardware monitor for an N-bit up/down counter with synchronous load: predicts each
// count from the previously sampled one and records mismatches and flag errors.
module counter_checker #(
    parameter int N     = 8,
    parameter bit SAT   = 1'b0,
    parameter int ERR_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             a,
    input  logic             b,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    input  logic             clr_err,
    output logic [N-1:0]     gold,
    output logic             mismatch,
    output logic             tick_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic [CYC_W-1:0] first_cyc,
    output logic [N-1:0]     first_exp,
    output logic [N-1:0]     first_got
);

    localparam logic [N-1:0]     ALL_ONES_N = {N{1'b1}};
    localparam logic [N-1:0]     ZERO_N     = {N{1'b0}};
    localparam logic [N-1:0]     ONE_N      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ZERO_ERR   = {ERR_W{1'b0}};
    localparam logic [CYC_W-1:0] ZERO_CYC   = {CYC_W{1'b0}};

    // Reference model of the counter; priority is load, then up, then down, then hold.
    function automatic logic [N-1:0] model_next(
        input logic         ld,
        input logic         en,
        input logic         up,
        input logic [N-1:0] dv,
        input logic [N-1:0] qv
    );
        logic [N-1:0] nxt;
        nxt = qv;
        if (ld) begin
            nxt = dv;
        end else if (en && up) begin
            if (SAT && (qv == ALL_ONES_N)) begin
                nxt = qv;
            end else begin
                nxt = qv + ONE_N;
            end
        end else if (en) begin
            if (SAT && (qv == ZERO_N)) begin
                nxt = qv;
            end else begin
                nxt = qv - ONE_N;
            end
        end else begin
            nxt = qv;
        end
        return nxt;
    endfunction

    // Generic saturating increment, used for both the error and cycle counters.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        r = v;
        if (v != {ERR_W{1'b1}}) begin
            r = v + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
        logic [CYC_W-1:0] r;
        r = v;
        if (v != {CYC_W{1'b1}}) begin
            r = v + {{(CYC_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic             ld_r, a_r, b_r, armed_r;
    logic [N-1:0]     d_r, q_r;
    logic [CYC_W-1:0] cyc_r;

    logic [N-1:0]     gold_r;
    logic             mismatch_r, tick_err_r, err_sticky_r;
    logic [ERR_W-1:0] err_cnt_r;
    logic [CYC_W-1:0] first_cyc_r;
    logic [N-1:0]     first_exp_r, first_got_r;

    logic [N-1:0]     exp_s;
    logic             chk_en_s, mismatch_s, tick_bad_s, fail_s;
    logic [ERR_W-1:0] err_cnt_n_s;
    logic             sticky_n_s;
    logic [CYC_W-1:0] first_cyc_n_s;
    logic [N-1:0]     first_exp_n_s, first_got_n_s;

    // Sample the counter's controls and output; the model is re-seeded from q_r every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_r    <= 1'b0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            d_r     <= ZERO_N;
            q_r     <= ZERO_N;
            armed_r <= 1'b0;
        end else begin
            ld_r    <= load;
            a_r     <= a;
            b_r     <= b;
            d_r     <= d;
            q_r     <= q;
            armed_r <= 1'b1;
        end
    end

    // Free-running cycle number used to timestamp the first failure.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r <= ZERO_CYC;
        end else begin
            cyc_r <= sat_inc_cyc(cyc_r);
        end
    end

    // Expected value and per-cycle check results.
    always_comb begin
        exp_s      = model_next(ld_r, a_r, b_r, d_r, q_r);
        chk_en_s   = armed_r & ~reset;
        mismatch_s = 1'b0;
        tick_bad_s = 1'b0;
        if (chk_en_s) begin
            mismatch_s = (q != exp_s);
            tick_bad_s = (max_tick != (q == ALL_ONES_N)) | (min_tick != (q == ZERO_N));
        end else begin
            mismatch_s = 1'b0;
            tick_bad_s = 1'b0;
        end
        fail_s = mismatch_s | tick_bad_s;
    end

    // Error bookkeeping: clr_err takes effect first so a same-cycle failure is still recorded.
    always_comb begin
        err_cnt_n_s   = err_cnt_r;
        sticky_n_s    = err_sticky_r;
        first_cyc_n_s = first_cyc_r;
        first_exp_n_s = first_exp_r;
        first_got_n_s = first_got_r;
        if (clr_err) begin
            err_cnt_n_s   = ZERO_ERR;
            sticky_n_s    = 1'b0;
            first_cyc_n_s = ZERO_CYC;
            first_exp_n_s = ZERO_N;
            first_got_n_s = ZERO_N;
        end else begin
            err_cnt_n_s   = err_cnt_r;
            sticky_n_s    = err_sticky_r;
        end
        if (fail_s) begin
            err_cnt_n_s = sat_inc_err(err_cnt_n_s);
            if (!sticky_n_s) begin
                first_cyc_n_s = cyc_r;
                first_exp_n_s = exp_s;
                first_got_n_s = q;
            end else begin
                first_cyc_n_s = first_cyc_n_s;
            end
            sticky_n_s = 1'b1;
        end else begin
            sticky_n_s = sticky_n_s;
        end
    end

    // Registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            gold_r       <= ZERO_N;
            mismatch_r   <= 1'b0;
            tick_err_r   <= 1'b0;
            err_cnt_r    <= ZERO_ERR;
            err_sticky_r <= 1'b0;
            first_cyc_r  <= ZERO_CYC;
            first_exp_r  <= ZERO_N;
            first_got_r  <= ZERO_N;
        end else begin
            if (chk_en_s) begin
                gold_r <= exp_s;
            end else begin
                gold_r <= gold_r;
            end
            mismatch_r   <= mismatch_s;
            tick_err_r   <= tick_bad_s;
            err_cnt_r    <= err_cnt_n_s;
            err_sticky_r <= sticky_n_s;
            first_cyc_r  <= first_cyc_n_s;
            first_exp_r  <= first_exp_n_s;
            first_got_r  <= first_got_n_s;
        end
    end

    assign gold       = gold_r;
    assign mismatch   = mismatch_r;
    assign tick_err   = tick_err_r;
    assign err_cnt    = err_cnt_r;
    assign err_sticky = err_sticky_r;
    assign first_cyc  = first_cyc_r;
    assign first_exp  = first_exp_r;
    assign first_got  = first_got_r;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a behavioural 4-bit counter drives two monitors,
// one wrapping (u_wrap) and one saturating (u_sat), with hand-computed expectations.
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        reset, load, a, b, clr_err, max_tick, min_tick;
    logic [3:0]  d, q, cnt;

    logic [3:0]  w_gold, w_first_exp, w_first_got, s_gold, s_first_exp, s_first_got;
    logic        w_mismatch, w_tick_err, w_err_sticky, s_mismatch, s_tick_err, s_err_sticky;
    logic [15:0] w_err_cnt, s_err_cnt;
    logic [31:0] w_first_cyc, s_first_cyc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_checker #(.N(4), .SAT(1'b0), .ERR_W(16), .CYC_W(32)) u_wrap (
        .clk(clk), .reset(reset), .load(load), .a(a), .b(b), .d(d), .q(q),
        .max_tick(max_tick), .min_tick(min_tick), .clr_err(clr_err),
        .gold(w_gold), .mismatch(w_mismatch), .tick_err(w_tick_err), .err_cnt(w_err_cnt),
        .err_sticky(w_err_sticky), .first_cyc(w_first_cyc), .first_exp(w_first_exp),
        .first_got(w_first_got)
    );

    counter_checker #(.N(4), .SAT(1'b1), .ERR_W(16), .CYC_W(32)) u_sat (
        .clk(clk), .reset(reset), .load(load), .a(a), .b(b), .d(d), .q(q),
        .max_tick(max_tick), .min_tick(min_tick), .clr_err(clr_err),
        .gold(s_gold), .mismatch(s_mismatch), .tick_err(s_tick_err), .err_cnt(s_err_cnt),
        .err_sticky(s_err_sticky), .first_cyc(s_first_cyc), .first_exp(s_first_exp),
        .first_got(s_first_got)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The counter's output jumps to v with consistent flags.
    task automatic set_cnt(input logic [3:0] v);
        cnt      = v;
        q        = v;
        max_tick = (v == 4'hF);
        min_tick = (v == 4'h0);
    endtask

    // Apply controls for one edge; the behavioural counter acts on that same edge.
    task automatic drive_cycle(input logic l, input logic en, input logic up,
                               input logic [3:0] dv, input bit sat);
        logic [3:0] nxt;
        load = l; a = en; b = up; d = dv;
        tick();
        if (l) nxt = dv;
        else if (en && up) nxt = (sat && cnt == 4'hF) ? 4'hF : cnt + 4'd1;
        else if (en) nxt = (sat && cnt == 4'h0) ? 4'h0 : cnt - 4'd1;
        else nxt = cnt;
        set_cnt(nxt);
    endtask

    task automatic do_reset;
        reset = 1'b1; load = 1'b0; a = 1'b0; b = 1'b0; d = 4'h0; clr_err = 1'b0;
        set_cnt(4'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (w_gold !== 4'h0) begin errors++; $display("FAIL rst_gold: got %0d expected 0", w_gold); end
        checks++; if (w_mismatch !== 1'b0) begin errors++; $display("FAIL rst_mismatch: got %0b expected 0", w_mismatch); end
        checks++; if (w_tick_err !== 1'b0) begin errors++; $display("FAIL rst_tick_err: got %0b expected 0", w_tick_err); end
        checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", w_err_cnt); end
        checks++; if (w_err_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %0b expected 0", w_err_sticky); end
        checks++; if (w_first_cyc !== 32'd0) begin errors++; $display("FAIL rst_first_cyc: got %0d expected 0", w_first_cyc); end
        checks++; if (w_first_exp !== 4'h0) begin errors++; $display("FAIL rst_first_exp: got %0d expected 0", w_first_exp); end
        checks++; if (w_first_got !== 4'h0) begin errors++; $display("FAIL rst_first_got: got %0d expected 0", w_first_got); end
        checks++; if (s_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_sat_err_cnt: got %0d expected 0", s_err_cnt); end
    endtask

    // Load 5 then count up 12 times through the wrap; gold lags q by one check.
    task automatic test_count_up;
        logic [3:0] eg;
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
        for (int i = 0; i < 13; i++) begin
            drive_cycle(1'b0, (i < 12), 1'b1, 4'd0, 1'b0);
            eg = 4'(5 + i);
            checks++; if (w_gold !== eg) begin errors++; $display("FAIL up_gold[%0d]: got %0d expected %0d", i, w_gold, eg); end
            checks++; if (w_mismatch !== 1'b0) begin errors++; $display("FAIL up_mismatch[%0d]: got %0b expected 0", i, w_mismatch); end
            checks++; if (w_tick_err !== 1'b0) begin errors++; $display("FAIL up_tick_err[%0d]: got %0b expected 0", i, w_tick_err); end
        end
        checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL up_err_cnt: got %0d expected 0", w_err_cnt); end
    endtask

    task automatic test_sat_down;
        logic [3:0] sg [4];
        logic       em;
        sg = '{4'd1, 4'd0, 4'd0, 4'd0};
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, (i < 3), 1'b0, 4'd0, 1'b1);
            checks++; if (s_gold !== sg[i]) begin errors++; $display("FAIL sat_gold[%0d]: got %0d expected %0d", i, s_gold, sg[i]); end
            checks++; if (s_mismatch !== 1'b0) begin errors++; $display("FAIL sat_mismatch[%0d]: got %0b expected 0", i, s_mismatch); end
        end
        checks++; if (s_err_cnt !== 16'd0) begin errors++; $display("FAIL sat_err_cnt: got %0d expected 0", s_err_cnt); end
        // Same stimulus, but the counter wraps 0 -> 15 where the saturating model holds 0.
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, (i < 3), 1'b0, 4'd0, 1'b0);
            em = (i == 2);
            checks++; if (s_mismatch !== em) begin errors++; $display("FAIL satwrap_mismatch[%0d]: got %0b expected %0b", i, s_mismatch, em); end
        end
        checks++; if (s_err_cnt !== 16'd1) begin errors++; $display("FAIL satwrap_err_cnt: got %0d expected 1", s_err_cnt); end
        checks++; if (s_first_exp !== 4'd0) begin errors++; $display("FAIL satwrap_first_exp: got %0d expected 0", s_first_exp); end
        checks++; if (s_first_got !== 4'd15) begin errors++; $display("FAIL satwrap_first_got: got %0d expected 15", s_first_got); end
        checks++; if (s_first_cyc !== 32'd3) begin errors++; $display("FAIL satwrap_first_cyc: got %0d expected 3", s_first_cyc); end
        checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL satwrap_wrap_err_cnt: got %0d expected 0", w_err_cnt); end
    endtask

    // Counter jumps by +3 after edges 20, 25, 30; failures are seen at edges 21, 26, 31.
    task automatic test_forced_errors;
        logic em;
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        for (int j = 2; j <= 32; j++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
            em = (j == 21) || (j == 26) || (j == 31);
            checks++; if (w_mismatch !== em) begin errors++; $display("FAIL forced_mismatch[%0d]: got %0b expected %0b", j, w_mismatch, em); end
            if (j == 20 || j == 25 || j == 30) set_cnt(cnt + 4'd3);
        end
        checks++; if (w_err_cnt !== 16'd3) begin errors++; $display("FAIL forced_err_cnt: got %0d expected 3", w_err_cnt); end
        checks++; if (w_err_sticky !== 1'b1) begin errors++; $display("FAIL forced_sticky: got %0b expected 1", w_err_sticky); end
        checks++; if (w_first_cyc !== 32'd20) begin errors++; $display("FAIL forced_first_cyc: got %0d expected 20", w_first_cyc); end
        checks++; if (w_first_exp !== 4'd6) begin errors++; $display("FAIL forced_first_exp: got %0d expected 6", w_first_exp); end
        checks++; if (w_first_got !== 4'd9) begin errors++; $display("FAIL forced_first_got: got %0d expected 9", w_first_got); end
    endtask

    task automatic test_tick_err;
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd15, 1'b0);
        max_tick = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (w_tick_err !== 1'b1) begin errors++; $display("FAIL tick_pulse: got %0b expected 1", w_tick_err); end
        checks++; if (w_mismatch !== 1'b0) begin errors++; $display("FAIL tick_mismatch: got %0b expected 0", w_mismatch); end
        checks++; if (w_err_cnt !== 16'd1) begin errors++; $display("FAIL tick_err_cnt: got %0d expected 1", w_err_cnt); end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (w_tick_err !== 1'b0) begin errors++; $display("FAIL tick_clear: got %0b expected 0", w_tick_err); end
        set_cnt(4'd7);
        max_tick = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (w_mismatch !== 1'b1) begin errors++; $display("FAIL both_mismatch: got %0b expected 1", w_mismatch); end
        checks++; if (w_tick_err !== 1'b1) begin errors++; $display("FAIL both_tick_err: got %0b expected 1", w_tick_err); end
        checks++; if (w_err_cnt !== 16'd2) begin errors++; $display("FAIL both_err_cnt: got %0d expected 2", w_err_cnt); end
        checks++; if (w_first_cyc !== 32'd1) begin errors++; $display("FAIL tick_first_cyc: got %0d expected 1", w_first_cyc); end
    endtask

    task automatic test_clr_err;
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        set_cnt(4'd3);
        clr_err = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        clr_err = 1'b0;
        checks++; if (w_err_cnt !== 16'd1) begin errors++; $display("FAIL clrfail_err_cnt: got %0d expected 1", w_err_cnt); end
        checks++; if (w_err_sticky !== 1'b1) begin errors++; $display("FAIL clrfail_sticky: got %0b expected 1", w_err_sticky); end
        checks++; if (w_first_cyc !== 32'd5) begin errors++; $display("FAIL clrfail_first_cyc: got %0d expected 5", w_first_cyc); end
        checks++; if (w_first_exp !== 4'd7) begin errors++; $display("FAIL clrfail_first_exp: got %0d expected 7", w_first_exp); end
        checks++; if (w_first_got !== 4'd3) begin errors++; $display("FAIL clrfail_first_got: got %0d expected 3", w_first_got); end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        clr_err = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        clr_err = 1'b0;
        checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL clr_err_cnt: got %0d expected 0", w_err_cnt); end
        checks++; if (w_err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky: got %0b expected 0", w_err_sticky); end
        checks++; if (w_first_cyc !== 32'd0) begin errors++; $display("FAIL clr_first_cyc: got %0d expected 0", w_first_cyc); end
        checks++; if (w_first_exp !== 4'd0) begin errors++; $display("FAIL clr_first_exp: got %0d expected 0", w_first_exp); end
        checks++; if (w_first_got !== 4'd0) begin errors++; $display("FAIL clr_first_got: got %0d expected 0", w_first_got); end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        set_cnt(4'd10);
        drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (w_first_cyc !== 32'd9) begin errors++; $display("FAIL clr_cyc_keeps: got %0d expected 9", w_first_cyc); end
        checks++; if (w_err_cnt !== 16'd1) begin errors++; $display("FAIL clr_refail_cnt: got %0d expected 1", w_err_cnt); end
    endtask

    task automatic test_reset_mid;
        set_cnt(4'd12);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
            max_tick = ~max_tick;
            checks++; if (w_mismatch !== 1'b0) begin errors++; $display("FAIL rstmid_mismatch[%0d]: got %0b expected 0", i, w_mismatch); end
            checks++; if (w_tick_err !== 1'b0) begin errors++; $display("FAIL rstmid_tick_err[%0d]: got %0b expected 0", i, w_tick_err); end
            checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_err_cnt[%0d]: got %0d expected 0", i, w_err_cnt); end
        end
        reset = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        max_tick = ~max_tick;
        checks++; if (w_tick_err !== 1'b0) begin errors++; $display("FAIL rstmid_first_edge: got %0b expected 0", w_tick_err); end
        checks++; if (w_err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_first_cnt: got %0d expected 0", w_err_cnt); end
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        checks++; if (w_tick_err !== 1'b1) begin errors++; $display("FAIL rstmid_resume: got %0b expected 1", w_tick_err); end
        checks++; if (w_mismatch !== 1'b0) begin errors++; $display("FAIL rstmid_resume_mm: got %0b expected 0", w_mismatch); end
        checks++; if (w_err_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_resume_cnt: got %0d expected 1", w_err_cnt); end
        checks++; if (w_first_cyc !== 32'd1) begin errors++; $display("FAIL rstmid_first_cyc: got %0d expected 1", w_first_cyc); end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; a = 1'b0; b = 1'b0; d = 4'h0; clr_err = 1'b0;
        set_cnt(4'h0);
        test_reset();
        test_count_up();
        test_sat_down();
        test_forced_errors();
        test_tick_err();
        test_clr_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
# counter_checker

Synthesizable self-checking monitor for an N-bit universal up/down counter with synchronous load. It tracks the counter's control inputs, computes the expected next count from the previously sampled count, and compares it with the counter output every cycle. Mismatches are reported as pulses, a saturating error count, a sticky flag and a first-failure capture. It sits beside the counter in simulation and on-board bring-up builds, and replaces the display-only monitor with hardware-visible results.

## Interface
- N, 8, counter width
- SAT, 0, 0 = model wraps at 2^N-1/0; 1 = model saturates at 2^N-1/0
- ERR_W, 16, error counter width
- CYC_W, 32, cycle counter width

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load  in  1  counter synchronous load
- a  in  1  counter enable
- b  in  1  direction: 1 = up, 0 = down (valid when a=1)
- d  in  N  counter load data
- q  in  N  counter output
- max_tick  in  1  counter's all-ones flag
- min_tick  in  1  counter's zero flag
- clr_err  in  1  synchronous clear of error state
- gold  out  N  expected value used in the latest check (registered)
- mismatch  out  1  one-cycle pulse: q != expected
- tick_err  out  1  one-cycle pulse: max_tick/min_tick inconsistent with q
- err_cnt  out  ERR_W  total failing checks, saturating at all-ones
- err_sticky  out  1  set on first failure, held until clr_err or reset
- first_cyc  out  CYC_W  cycle number of first failure
- first_exp  out  N  expected value at first failure
- first_got  out  N  q at first failure

## Operation
- Each edge registers load, a, b, d and q into ld_r, a_r, b_r, d_r, q_r, and sets armed <= ~reset.
- Expected value exp (combinational), by priority:
  - ld_r: d_r
  - a_r & b_r: q_r+1. Wraps mod 2^N; if SAT=1, holds at 2^N-1.
  - a_r & ~b_r: q_r-1. Wraps; if SAT=1, holds at 0.
  - otherwise: q_r
- The model is re-seeded from the sampled q every cycle, so one error does not cascade.
- Check enable: armed & ~reset.
- When enabled:
  - mismatch = (q != exp).
  - tick_err = (max_tick != (q == all-ones)) | (min_tick != (q == 0)).
  - The check fails if mismatch | tick_err. A cycle with both counts as one failure.
- On a failing check:
  - err_cnt increments, saturating at all-ones.
  - err_sticky <= 1.
  - If err_sticky was 0, capture first_cyc = cyc, first_exp = exp, first_got = q.
- cyc is an internal counter: cleared by reset, incremented every non-reset cycle, saturating at all-ones. clr_err does not affect it.
- clr_err clears err_cnt, err_sticky and the first_* registers. If a failing check occurs in the same cycle as clr_err, the clear applies first and the failure is then recorded: err_cnt=1, sticky=1, captured.
- gold <= exp on every enabled cycle; otherwise gold holds.

## Timing
- Reset values: gold=0, mismatch=0, tick_err=0, err_cnt=0, err_sticky=0, first_cyc=0, first_exp=0, first_got=0. Internally, armed=0 and cyc=0.
- Latency: control applied before edge k, which the counter acts on at edge k, is checked at edge k+1. All outputs are valid after edge k+1.
- After reset deasserts, the first edge only samples (armed becomes 1). Checking starts at the second edge.
- Reset asserted mid-run:
  - Clears all state at that edge.
  - Suppresses checks during reset.
  - Re-arms as above.
- mismatch and tick_err are single-cycle pulses. Consecutive failing cycles give consecutive high cycles.

## Test plan
- N=4, SAT=0. Reset 2 cycles; load d=5; then up 12 cycles with a correct counter. Required: q passes 5→15→0→1; mismatch stays 0; err_cnt=0; gold tracks q.
- SAT=1. Load 1, then down 3 cycles. Counter models a correct saturating counter (1, 0, 0, 0). Required: no errors. Repeat with a wrapping counter (1, 0, 15): mismatch pulses exactly at the 15 cycle, first_exp=0, first_got=15.
- Force q wrong on 3 separated cycles, first at cyc=20. Required:
  - err_cnt=3.
  - err_sticky=1.
  - first_cyc=20 with the captured exp/got.
  - The second and third failures do not overwrite the first_* registers.
- Hold max_tick=0 while q=15. Required: tick_err pulses, mismatch=0, err_cnt increments by 1. With both wrong in one cycle, err_cnt increments by exactly 1.
- Assert clr_err in the same cycle as a failing check. Required: err_cnt=1 and sticky=1 afterwards, with the first_* registers holding the new failure. Assert clr_err alone: all error state returns to 0 and cyc keeps counting.
- Assert reset mid-run while q is corrupted. Required: no mismatch during reset or on the first edge after it. Checking resumes on the second edge. err_cnt starts from 0 and cyc restarts from 0.
